// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-period helper
package uart_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction
endpackage

// File: rtl/uart_tx_serialiser_if.sv
// uart_tx_serialiser_if: byte request handshake and serial line of the UART transmitter
interface uart_tx_serialiser_if #(
    parameter int PAYLOAD_BITS = 8
) ();
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_txd;
    logic                    uart_tx_busy;
    logic                    uart_tx_done;
    modport master (
        output uart_tx_en, uart_tx_data,
        input  uart_txd, uart_tx_busy, uart_tx_done
    );
    modport slave (
        input  uart_tx_en, uart_tx_data,
        output uart_txd, uart_tx_busy, uart_tx_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter producing a one-cycle bit_end pulse
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic bit_end_o
);
    localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W = $clog2(CPB + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CPB - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign bit_end_o = run_i && cnt_q == '0;
    // reload on accept and at every bit boundary, otherwise count down while a frame runs
    always_comb cnt_d = (load_i || bit_end_o) ? RELOAD : run_i ? cnt_q - CNT_W'(1) : cnt_q;
    // bit-period counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_serialiser.sv
// uart_tx_serialiser: 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even parity bit
module uart_tx_serialiser
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input logic               clk,
    input logic               rst,
    uart_tx_serialiser_if.slave tx
);
    localparam int IDX_W = $clog2(PAYLOAD_BITS + STOP_BITS + 1);
`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic                    txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic                    accept, bit_end, par_bit, last_data, last_stop;
    assign accept    = tx.uart_tx_en && !busy_q;
    assign last_data = idx_q == IDX_W'(PAYLOAD_BITS - 1);
    assign last_stop = idx_q == IDX_W'(STOP_BITS - 1);
    assign tx.uart_txd     = txd_q;
    assign tx.uart_tx_busy = busy_q;
    assign tx.uart_tx_done = done_q;
    uart_baud_tick #(
        .BIT_RATE (BIT_RATE),
        .CLK_HZ   (CLK_HZ)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .run_i     (busy_q),
        .bit_end_o (bit_end)
    );
`ifdef UART_TX_PARITY_EN
    logic par_q;
    // even parity of the payload captured with the request
    always_ff @(posedge clk or posedge rst)
        if (rst) par_q <= 1'b0;
        else if (accept) par_q <= ^tx.uart_tx_data;
    assign par_bit = par_q;
`else
    assign par_bit = 1'b1;
`endif
    // state register with registered line outputs so uart_txd never glitches
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    // next-state: advance one frame slot per bit_end, shifting payload LSB first
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                idx_d   = '0;
                shreg_d = tx.uart_tx_data;
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                idx_d   = last_data ? '0 : idx_q + IDX_W'(1);
                state_d = last_data ? AFTER_DATA : DATA;
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                idx_d   = '0;
            end
            STOP: if (bit_end) begin
                idx_d   = last_stop ? '0 : idx_q + IDX_W'(1);
                state_d = last_stop ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs derived from the upcoming state so the line changes on the same edge
    always_comb begin
        txd_d  = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_bit : 1'b1;
        busy_d = state_d != IDLE;
        done_d = state_q != IDLE && state_d == IDLE;
    end
endmodule

// File: tb/tb_uart_tx_serialiser.sv
// tb_uart_tx_serialiser: randomized self-checking bench against a frame-level line model
module tb_uart_tx_serialiser;
    localparam int CLK_HZ   = 70;
    localparam int BIT_RATE = 10;
    localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB    = 10 + PAR;
    localparam int FRAME = NB * CPB;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    uart_tx_serialiser_if #(.PAYLOAD_BITS(8)) tx_if ();
    uart_tx_serialiser #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tx  (tx_if)
    );
    always #5 clk = ~clk;

    function automatic logic exp_txd(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int bad = 0;
        rst = 1'b1;
        tx_if.uart_tx_en = 1'b0;
        tx_if.uart_tx_data = 8'h00;
        #4000;
        checks++; if (tx_if.uart_txd !== 1'b1) begin errors++; $display("FAIL reset txd got %b want 1", tx_if.uart_txd); end
        checks++; if (tx_if.uart_tx_busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", tx_if.uart_tx_busy); end
        checks++; if (tx_if.uart_tx_done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", tx_if.uart_tx_done); end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0 || tx_if.uart_tx_done !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_line bad_cycles got %0d want 0", bad); end
    endtask

    task automatic test_single(input logic [7:0] d);
        int busy_cyc = 0;
        int done_cnt = 0;
        logic e;
        tx_if.uart_tx_en = 1'b1;
        tx_if.uart_tx_data = d;
        tick;
        tx_if.uart_tx_en = 1'b0;
        tx_if.uart_tx_data = ~d;
        for (int k = 0; k < FRAME + 2 * CPB; k++) begin
            e = k < FRAME ? exp_txd(d, k) : 1'b1;
            checks++; if (tx_if.uart_txd !== e) begin errors++; $display("FAIL single_txd d=%h k=%0d got %b want %b", d, k, tx_if.uart_txd, e); end
            if (k == FRAME) begin
                checks++; if (tx_if.uart_tx_done !== 1'b1) begin errors++; $display("FAIL single_done_time d=%h got %b want 1", d, tx_if.uart_tx_done); end
            end
            busy_cyc += int'(tx_if.uart_tx_busy);
            done_cnt += int'(tx_if.uart_tx_done);
            tick;
        end
        checks++; if (busy_cyc !== FRAME) begin errors++; $display("FAIL single_busy_len d=%h got %0d want %0d", d, busy_cyc, FRAME); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_count d=%h got %0d want 1", d, done_cnt); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) test_single(8'($urandom));
    endtask

    task automatic test_ignored;
        int busy_cyc = 0;
        tx_if.uart_tx_en = 1'b1;
        tx_if.uart_tx_data = 8'h00;
        tick;
        tx_if.uart_tx_en = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx_if.uart_txd !== exp_txd(8'h00, k)) begin errors++; $display("FAIL ignored_txd k=%0d got %b want %b", k, tx_if.uart_txd, exp_txd(8'h00, k)); end
            if (k == 3 * CPB) begin tx_if.uart_tx_en = 1'b1; tx_if.uart_tx_data = 8'hFF; end
            if (k == 3 * CPB + 4) tx_if.uart_tx_en = 1'b0;
            tick;
        end
        for (int k = 0; k < 3 * CPB; k++) begin
            busy_cyc += int'(tx_if.uart_tx_busy);
            checks++; if (tx_if.uart_txd !== 1'b1) begin errors++; $display("FAIL ignored_idle k=%0d got %b want 1", k, tx_if.uart_txd); end
            tick;
        end
        checks++; if (busy_cyc !== 0) begin errors++; $display("FAIL ignored_second_frame busy_cycles got %0d want 0", busy_cyc); end
    endtask

    task automatic test_back_to_back;
        time t1, t2;
        tx_if.uart_tx_en = 1'b1;
        tx_if.uart_tx_data = 8'h55;
        tick;
        t1 = $time;
        tx_if.uart_tx_data = 8'h3C;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx_if.uart_txd !== exp_txd(8'h55, k)) begin errors++; $display("FAIL b2b_first k=%0d got %b want %b", k, tx_if.uart_txd, exp_txd(8'h55, k)); end
            tick;
        end
        checks++; if (tx_if.uart_tx_done !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%b busy=%b want done=1 busy=0", tx_if.uart_tx_done, tx_if.uart_tx_busy); end
        tick;
        tx_if.uart_tx_en = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx_if.uart_txd !== exp_txd(8'h3C, k) || tx_if.uart_tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_second k=%0d got txd=%b busy=%b want txd=%b busy=1", k, tx_if.uart_txd, tx_if.uart_tx_busy, exp_txd(8'h3C, k)); end
            tick;
        end
        t2 = $time;
        checks++; if (tx_if.uart_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", tx_if.uart_tx_done); end
        checks++; if ((t2 - t1) / 10 !== (2 * FRAME + 1)) begin errors++; $display("FAIL b2b_total_cycles got %0d want %0d", (t2 - t1) / 10, 2 * FRAME + 1); end
        tick;
    endtask

    task automatic test_async_reset;
        tx_if.uart_tx_en = 1'b1;
        tx_if.uart_tx_data = 8'h0F;
        tick;
        tx_if.uart_tx_en = 1'b0;
        for (int k = 0; k < 4 * CPB + 2; k++) begin
            checks++; if (tx_if.uart_txd !== exp_txd(8'h0F, k)) begin errors++; $display("FAIL areset_pre k=%0d got %b want %b", k, tx_if.uart_txd, exp_txd(8'h0F, k)); end
            tick;
        end
        rst = 1'b1;
        #1;
        checks++; if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin errors++; $display("FAIL areset_immediate got txd=%b busy=%b want txd=1 busy=0", tx_if.uart_txd, tx_if.uart_tx_busy); end
        tick;
        tick;
        rst = 1'b0;
        tick;
        checks++; if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_done !== 1'b0) begin errors++; $display("FAIL areset_no_resume got txd=%b done=%b want txd=1 done=0", tx_if.uart_txd, tx_if.uart_tx_done); end
        test_single(8'h81);
    endtask

    task automatic test_loopback;
        logic [31:0] word;
        logic [7:0]  rx, want;
        word = 32'h001f7793;
        for (int i = 0; i < 4; i++) begin
            want = word[8*i +: 8];
            rx = 8'h00;
            tx_if.uart_tx_en = 1'b1;
            tx_if.uart_tx_data = want;
            tick;
            tx_if.uart_tx_en = 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) rx[k / CPB - 1] = tx_if.uart_txd;
                if (k == (NB - 1) * CPB + CPB / 2) begin
                    checks++; if (tx_if.uart_txd !== 1'b1) begin errors++; $display("FAIL loopback_stop byte=%0d got %b want 1", i, tx_if.uart_txd); end
                end
                tick;
            end
            checks++; if (rx !== want) begin errors++; $display("FAIL loopback_data byte=%0d got %h want %h", i, rx, want); end
            checks++; if (tx_if.uart_tx_done !== 1'b1) begin errors++; $display("FAIL loopback_valid byte=%0d got %b want 1", i, tx_if.uart_tx_done); end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_single(8'hA5);
        test_random;
        test_ignored;
        test_back_to_back;
        test_async_reset;
        test_loopback;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
